// File: rtl/mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// mem_loader_pkg
// Shared definitions for the stream-to-BRAM frame loader.
//   state_t  : loader FSM states
//   BASE_IDX : header beat index that carries the write base address
//   LEN_IDX  : header beat index that carries the payload length
// ---------------------------------------------------------------------------
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for the base beat
    ST_LEN   = 3'd1,  // waiting for the length beat
    ST_DATA  = 3'd2,  // writing payload beats (and checksum beat if enabled)
    ST_RESP  = 3'd3,  // one-cycle response, stream stalled
    ST_DRAIN = 3'd4   // discarding beats of a bad frame until s_last
  } state_t;

  localparam int BASE_IDX = 0;
  localparam int LEN_IDX  = 1;

endpackage

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
// Receives framed beats {base, length N, N data beats} and writes the payload
// into a BRAM write port at base..base+N-1, then reports good/bad frame.
//
// Optional feature (macro LOADER_CHECKSUM_EN): one extra beat follows the
// payload holding the XOR of all payload beats; a mismatch rejects the frame
// (payload writes already made are kept).
//
// Ports
//   CLK100MHZ   : clock, everything updates on its rising edge
//   reset       : asynchronous active-high reset
//   s_data      : stream beat           s_valid / s_ready : handshake
//   s_last      : final beat of a frame
//   mem_we      : BRAM write strobe     mem_addr / mem_wdata : write address/data
//   load_done   : one-cycle pulse for a good frame
//   load_err    : one-cycle pulse for a rejected frame
//   loaded_base : base of the last good frame
//   loaded_len  : length of the last good frame
// ---------------------------------------------------------------------------
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] loaded_base,
  output logic [ADDR_W-1:0] loaded_len
);

  localparam logic [ADDR_W:0]   ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, len_reg, cnt_reg;
  logic              mem_we_reg, load_done_reg, load_err_reg;
  logic [ADDR_W-1:0] mem_addr_reg, loaded_base_reg, loaded_len_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_reg;
`else
  logic              last_data;
`endif

  logic [ADDR_W-1:0] beat_field;   // header beat resized to address width
  logic              accept;
  logic              fits;         // base + N stays inside the address space
  logic              wr_en, go_resp, resp_good;

  // Header beats carry address-width fields; zero-extend or truncate.
  if (DATA_W >= ADDR_W) begin : g_field_trunc
    assign beat_field = s_data[ADDR_W-1:0];
  end else begin : g_field_ext
    assign beat_field = {{(ADDR_W-DATA_W){1'b0}}, s_data};
  end

  // Stream is stalled only during the response cycle and while in reset.
  assign s_ready = !reset && (state_reg != ST_RESP);
  assign accept  = s_valid && s_ready;
  // One bit wider than the address so base+N == 2^ADDR_W is still legal.
  assign fits    = ({1'b0, base_reg} + {1'b0, beat_field}) <= ADDR_SPAN;
`ifndef LOADER_CHECKSUM_EN
  assign last_data = (cnt_reg == len_reg - ONE);
`endif

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    go_resp    = 1'b0;
    resp_good  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          // A frame that ends on its base beat is malformed.
          if (s_last) begin
            state_next = ST_RESP;
            go_resp    = 1'b1;
          end else begin
            state_next = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (!fits) begin
            if (s_last) begin
              state_next = ST_RESP;
              go_resp    = 1'b1;
            end else begin
              state_next = ST_DRAIN;
            end
`ifdef LOADER_CHECKSUM_EN
          // Even N=0 carries a checksum beat, so the length beat cannot end it.
          end else if (s_last) begin
            state_next = ST_RESP;
            go_resp    = 1'b1;
          end else begin
            state_next = ST_DATA;
          end
`else
          end else if (beat_field == '0) begin
            if (s_last) begin
              state_next = ST_RESP;
              go_resp    = 1'b1;
              resp_good  = 1'b1;
            end else begin
              state_next = ST_DRAIN;
            end
          end else if (s_last) begin
            state_next = ST_RESP;
            go_resp    = 1'b1;
          end else begin
            state_next = ST_DATA;
          end
`endif
        end
      end
      ST_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          if (cnt_reg == len_reg) begin
            // Checksum beat: all N payload beats already written.
            if (s_last) begin
              state_next = ST_RESP;
              go_resp    = 1'b1;
              resp_good  = (s_data == csum_reg);
            end else begin
              state_next = ST_DRAIN;
            end
          end else begin
            wr_en = 1'b1;
            if (s_last) begin
              state_next = ST_RESP;
              go_resp    = 1'b1;
            end
          end
`else
          wr_en = 1'b1;
          if (last_data) begin
            if (s_last) begin
              state_next = ST_RESP;
              go_resp    = 1'b1;
              resp_good  = 1'b1;
            end else begin
              state_next = ST_DRAIN;
            end
          end else if (s_last) begin
            state_next = ST_RESP;
            go_resp    = 1'b1;
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (accept && s_last) begin
          state_next = ST_RESP;
          go_resp    = 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      base_reg        <= '0;
      len_reg         <= '0;
      cnt_reg         <= '0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      load_done_reg   <= 1'b0;
      load_err_reg    <= 1'b0;
      loaded_base_reg <= '0;
      loaded_len_reg  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg        <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      mem_we_reg    <= wr_en;
      // Pulses are registered so they coincide with the RESP cycle.
      load_done_reg <= go_resp && resp_good;
      load_err_reg  <= go_resp && !resp_good;
      if (state_reg == ST_IDLE && accept) begin
        base_reg <= beat_field;
      end
      if (state_reg == ST_LEN && accept) begin
        len_reg  <= beat_field;
        cnt_reg  <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_reg <= '0;
`endif
      end
      if (wr_en) begin
        mem_addr_reg  <= base_reg + cnt_reg;
        mem_wdata_reg <= s_data;
        cnt_reg       <= cnt_reg + ONE;
`ifdef LOADER_CHECKSUM_EN
        csum_reg      <= csum_reg ^ s_data;
`endif
      end
      if (go_resp && resp_good) begin
        loaded_base_reg <= base_reg;
        // An empty frame finishes on its length beat, before len_reg updates.
        loaded_len_reg  <= (state_reg == ST_LEN) ? beat_field : len_reg;
      end
    end
  end

  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign load_done   = load_done_reg;
  assign load_err    = load_err_reg;
  assign loaded_base = loaded_base_reg;
  assign loaded_len  = loaded_len_reg;

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
// Self-checking bench for mem_loader (default 8-bit address/data). Expected
// writes and responses are queued when frames are driven; a negedge monitor
// pops and compares them as the DUT produces them. Define LOADER_CHECKSUM_EN
// to exercise the checksum beat.
// ---------------------------------------------------------------------------
module tb_mem_loader;

  typedef struct packed {
    logic       good;
    logic [7:0] base;
    logic [7:0] len;
  } resp_t;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, mem_we, load_done, load_err;
  logic [7:0] mem_addr, mem_wdata, loaded_base, loaded_len;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_seen = 0;

  logic [15:0] wr_q[$];
  resp_t       resp_q[$];
  logic [7:0]  payload[$];
  logic [7:0]  model_base = '0;
  logic [7:0]  model_len  = '0;
  logic [15:0] exp_wr;
  resp_t       exp_rsp;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_done  (load_done),
    .load_err   (load_err),
    .loaded_base(loaded_base),
    .loaded_len (loaded_len)
  );

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        n_tests++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got addr=%0d data=%0d, required no write", mem_addr, mem_wdata);
        end else begin
          exp_wr = wr_q.pop_front();
          $display("[TB] write addr=%0d data=%0d", mem_addr, mem_wdata);
          if ({mem_addr, mem_wdata} !== exp_wr) begin
            n_fail++;
            $display("FAIL write_value: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     mem_addr, mem_wdata, exp_wr[15:8], exp_wr[7:0]);
          end
        end
      end
      if (load_done || load_err) begin
        resp_seen++;
        n_tests++;
        if (resp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got done=%0b err=%0b, required no pulse", load_done, load_err);
        end else begin
          exp_rsp = resp_q.pop_front();
          $display("[TB] resp done=%0b err=%0b base=%0d len=%0d", load_done, load_err, loaded_base, loaded_len);
          if ({load_done, load_err, loaded_base, loaded_len} !==
              {exp_rsp.good, !exp_rsp.good, exp_rsp.base, exp_rsp.len}) begin
            n_fail++;
            $display("FAIL resp_value: got done=%0b err=%0b base=%0d len=%0d, required done=%0b err=%0b base=%0d len=%0d",
                     load_done, load_err, loaded_base, loaded_len,
                     exp_rsp.good, !exp_rsp.good, exp_rsp.base, exp_rsp.len);
          end
        end
        n_tests++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL resp_ready: got s_ready=%0b, required 0", s_ready);
        end
      end
    end
  end

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic push_resp(input bit good, input logic [7:0] b, input logic [7:0] l);
    resp_t r;
    if (good) begin
      model_base = b;
      model_len  = l;
    end
    r.good = good;
    r.base = model_base;
    r.len  = model_len;
    resp_q.push_back(r);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_data = 8'($urandom);
      s_last = 1'($urandom);
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [7:0] d, input bit last);
    int guard;
    guard   = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (s_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got s_ready=%0b, required 1 within 50 cycles", s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] len,
                            input bit with_csum, input int gap);
    logic [7:0] beats[$];
    logic [7:0] cs;
    cs = '0;
    beats.push_back(base);
    beats.push_back(len);
    foreach (payload[i]) begin
      beats.push_back(payload[i]);
      cs = cs ^ payload[i];
    end
    if (with_csum && CSUM_ON) beats.push_back(cs);
    foreach (beats[i]) begin
      send_beat(beats[i], i == beats.size() - 1);
      if (gap > 0 && i != beats.size() - 1) idle(gap);
    end
  endtask

  // Waits for all queued responses, then confirms no write is outstanding.
  task automatic finish_frame(input string name);
    int guard;
    guard = 0;
    while (resp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (resp_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d responses and %0d writes outstanding, required 0 and 0",
               name, resp_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({s_ready, mem_we, load_done, load_err, mem_addr, mem_wdata, loaded_base, loaded_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b we=%0b done=%0b err=%0b addr=%0d wd=%0d lb=%0d ll=%0d, required all 0",
               s_ready, mem_we, load_done, load_err, mem_addr, mem_wdata, loaded_base, loaded_len);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got s_ready=%0b, required 1", s_ready);
    end
  endtask

  task automatic test_good_frame();
    payload = '{8'd78, 8'd77};
    push_write(8'd14, 8'd78);
    push_write(8'd15, 8'd77);
    push_resp(1'b1, 8'd14, 8'd2);
    send_frame(8'd14, 8'd2, 1'b1, 0);
    finish_frame("good_frame");
  endtask

  task automatic test_empty_frame();
    payload = {};
    push_resp(1'b1, 8'd0, 8'd0);
    send_frame(8'd0, 8'd0, 1'b1, 0);
    finish_frame("empty_frame");
  endtask

  task automatic test_overflow();
    payload = {};
    for (int i = 0; i < 10; i++) payload.push_back(8'(i + 100));
    push_resp(1'b0, 8'd0, 8'd0);
    send_frame(8'd250, 8'd10, 1'b1, 1);
    finish_frame("overflow");
  endtask

  task automatic test_short_frame();
    payload = '{8'd1, 8'd2};
    push_write(8'd0, 8'd1);
    push_write(8'd1, 8'd2);
    push_resp(1'b0, 8'd0, 8'd0);
    send_frame(8'd0, 8'd3, 1'b0, 0);
    finish_frame("short_frame");
  endtask

  task automatic test_header_last();
    push_resp(1'b0, 8'd0, 8'd0);
    send_beat(8'd7, 1'b1);
    finish_frame("header_last");
  endtask

  task automatic test_reset_mid_frame();
    int seen_before;
    // Leave loaded_* nonzero so the reset clearing them is visible.
    payload = '{8'd33};
    push_write(8'd40, 8'd33);
    push_resp(1'b1, 8'd40, 8'd1);
    send_frame(8'd40, 8'd1, 1'b1, 0);
    finish_frame("pre_reset");
    push_write(8'd20, 8'd1);
    push_write(8'd21, 8'd2);
    send_beat(8'd20, 1'b0);
    send_beat(8'd4, 1'b0);
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b0);
    seen_before = resp_seen;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({s_ready, mem_we, load_done, load_err, mem_addr, mem_wdata, loaded_base, loaded_len} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%0b we=%0b done=%0b err=%0b addr=%0d wd=%0d lb=%0d ll=%0d, required all 0",
               s_ready, mem_we, load_done, load_err, mem_addr, mem_wdata, loaded_base, loaded_len);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_base = '0;
    model_len  = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (resp_seen !== seen_before || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_no_pulse: got %0d new pulses and %0d writes pending, required 0 and 0",
               resp_seen - seen_before, wr_q.size());
    end
    payload = '{8'd9};
    push_write(8'd5, 8'd9);
    push_resp(1'b1, 8'd5, 8'd1);
    send_frame(8'd5, 8'd1, 1'b1, 0);
    finish_frame("post_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] len, base;
    for (int f = 0; f < 6; f++) begin
      len  = 8'($urandom_range(8, 1));
      base = 8'($urandom_range(256 - int'(len), 0));
      payload = {};
      for (int k = 0; k < int'(len); k++) begin
        payload.push_back(8'($urandom));
        push_write(base + 8'(k), payload[k]);
      end
      push_resp(1'b1, base, len);
      send_frame(base, len, 1'b1, f % 3);
    end
    // Frame ending exactly at the top of the address space.
    payload = '{8'hA5, 8'h5A};
    push_write(8'd254, 8'hA5);
    push_write(8'd255, 8'h5A);
    push_resp(1'b1, 8'd254, 8'd2);
    send_frame(8'd254, 8'd2, 1'b1, 0);
    finish_frame("back_to_back");
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    push_write(8'd0, 8'd3);
    push_write(8'd1, 8'd5);
    push_resp(1'b1, 8'd0, 8'd2);
    send_beat(8'd0, 1'b0);
    send_beat(8'd2, 1'b0);
    send_beat(8'd3, 1'b0);
    send_beat(8'd5, 1'b0);
    send_beat(8'd6, 1'b1);
    push_write(8'd0, 8'd3);
    push_write(8'd1, 8'd5);
    push_resp(1'b0, 8'd0, 8'd0);
    send_beat(8'd0, 1'b0);
    send_beat(8'd2, 1'b0);
    send_beat(8'd3, 1'b0);
    send_beat(8'd5, 1'b0);
    send_beat(8'd7, 1'b1);
    finish_frame("checksum");
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_empty_frame();
    test_overflow();
    test_short_frame();
    test_header_last();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
